// File: rtl/next_pc_btb.sv
// Fully-associative branch target buffer for the fetch stage.
// Predicts the next fetch PC from the current fetch PC and trains on branch
// outcomes that execute has resolved. New entries go into the slot picked by
// an external replacement allocator, which is told about update-side hits
// and allocations.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   pc_f_i               current fetch PC
//   next_pc_f_o          predicted next fetch PC (word aligned)
//   next_taken_f_o       prediction comes from a taken BTB hit
//   branch_request_i     resolved control-flow instruction valid this cycle
//   branch_is_taken_i    resolved outcome
//   branch_source_i      PC of the resolved instruction
//   branch_pc_i          resolved target PC
//   invalidate_i         flush every entry
//   hit_o, hit_entry_o   update-side hit and its index, to the allocator
//   alloc_o              allocation this cycle, to the allocator
//   alloc_entry_i        slot chosen by the allocator
module next_pc_btb #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       pc_f_i,
  output logic [31:0]       next_pc_f_o,
  output logic              next_taken_f_o,
  input  logic              branch_request_i,
  input  logic              branch_is_taken_i,
  input  logic [31:0]       branch_source_i,
  input  logic [31:0]       branch_pc_i,
  input  logic              invalidate_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] hit_entry_o,
  output logic              alloc_o,
  input  logic [ADDR_W-1:0] alloc_entry_i
);

  logic        valid_q  [DEPTH];
  logic        valid_d  [DEPTH];
  logic [29:0] source_q [DEPTH];
  logic [29:0] source_d [DEPTH];
  logic [29:0] target_q [DEPTH];
  logic [29:0] target_d [DEPTH];
  logic [1:0]  cnt_q    [DEPTH];
  logic [1:0]  cnt_d    [DEPTH];

  logic              l_hit;
  logic [ADDR_W-1:0] l_idx;
  logic              u_hit;
  logic [ADDR_W-1:0] u_idx;

  // PC bits [1:0] carry no information for word-aligned instructions.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_f_i[1:0], branch_source_i[1:0], branch_pc_i[1:0]};

  // Lookup and update match; the first (lowest-index) match wins.
  always_comb begin
    l_hit = 1'b0;
    l_idx = '0;
    u_hit = 1'b0;
    u_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!l_hit && valid_q[i] && source_q[i] == pc_f_i[31:2]) begin
        l_hit = 1'b1;
        l_idx = ADDR_W'(i);
      end
      if (!u_hit && valid_q[i] && source_q[i] == branch_source_i[31:2]) begin
        u_hit = 1'b1;
        u_idx = ADDR_W'(i);
      end
    end
  end

  always_comb begin
    if (l_hit && cnt_q[l_idx][1]) begin
      next_pc_f_o    = {target_q[l_idx], 2'b00};
      next_taken_f_o = 1'b1;
    end else begin
      next_pc_f_o    = {pc_f_i[31:2] + 30'd1, 2'b00};
      next_taken_f_o = 1'b0;
    end
  end

  assign hit_o       = branch_request_i && u_hit && !invalidate_i;
  assign hit_entry_o = u_idx;
  // Gated by reset so the allocator never sees an allocation that is discarded.
  assign alloc_o     = rst_ni && branch_request_i && branch_is_taken_i && !u_hit &&
                       !invalidate_i;

  always_comb begin
    valid_d  = valid_q;
    source_d = source_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (invalidate_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (branch_request_i) begin
      if (u_hit) begin
        if (branch_is_taken_i) begin
          if (cnt_q[u_idx] != 2'b11) cnt_d[u_idx] = cnt_q[u_idx] + 2'd1;
          target_d[u_idx] = branch_pc_i[31:2];
        end else begin
          if (cnt_q[u_idx] != 2'b00) cnt_d[u_idx] = cnt_q[u_idx] - 2'd1;
        end
      end else if (branch_is_taken_i) begin
        valid_d[alloc_entry_i]  = 1'b1;
        source_d[alloc_entry_i] = branch_source_i[31:2];
        target_d[alloc_entry_i] = branch_pc_i[31:2];
        cnt_d[alloc_entry_i]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i]  <= 1'b0;
        source_q[i] <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b00;
      end
    end else begin
      valid_q  <= valid_d;
      source_q <= source_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_next_pc_btb.sv
module tb_next_pc_btb;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] pc_f_i = 32'h100;
  logic [31:0] next_pc_f_o;
  logic        next_taken_f_o;
  logic        branch_request_i = 1'b0;
  logic        branch_is_taken_i = 1'b0;
  logic [31:0] branch_source_i = '0;
  logic [31:0] branch_pc_i = '0;
  logic        invalidate_i = 1'b0;
  logic        hit_o;
  logic [4:0]  hit_entry_o;
  logic        alloc_o;
  logic [4:0]  alloc_entry_i = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] npc;
    logic        tk;
    logic        hit;
    logic [4:0]  hent;
    logic        alloc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  next_pc_btb #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .pc_f_i           (pc_f_i),
    .next_pc_f_o      (next_pc_f_o),
    .next_taken_f_o   (next_taken_f_o),
    .branch_request_i (branch_request_i),
    .branch_is_taken_i(branch_is_taken_i),
    .branch_source_i  (branch_source_i),
    .branch_pc_i      (branch_pc_i),
    .invalidate_i     (invalidate_i),
    .hit_o            (hit_o),
    .hit_entry_o      (hit_entry_o),
    .alloc_o          (alloc_o),
    .alloc_entry_i    (alloc_entry_i)
  );

  // Monitor: the DUT presents a fresh output set every cycle; compare at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({next_pc_f_o, next_taken_f_o, hit_o, hit_entry_o, alloc_o} !==
          {e.npc, e.tk, e.hit, e.hent, e.alloc}) begin
        failures++;
        $display("FAIL %s: got npc=%h tk=%b hit=%b ent=%0d alloc=%b, want npc=%h tk=%b hit=%b ent=%0d alloc=%b",
                 e.nm, next_pc_f_o, next_taken_f_o, hit_o, hit_entry_o, alloc_o,
                 e.npc, e.tk, e.hit, e.hent, e.alloc);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [31:0] npc, input logic tk,
                            input logic hit, input logic [4:0] hent, input logic alloc);
    exp_t e;
    e.nm = nm; e.npc = npc; e.tk = tk; e.hit = hit; e.hent = hent; e.alloc = alloc;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge, queue the expected response.
  task automatic cyc(input string nm, input logic req, input logic tk,
                     input logic [31:0] src, input logic [31:0] tgt, input logic inv,
                     input logic [4:0] ae, input logic [31:0] pc,
                     input logic [31:0] e_npc, input logic e_tk, input logic e_hit,
                     input logic [4:0] e_hent, input logic e_alloc);
    @(posedge clk);
    #1;
    branch_request_i  = req;
    branch_is_taken_i = tk;
    branch_source_i   = src;
    branch_pc_i       = tgt;
    invalidate_i      = inv;
    alloc_entry_i     = ae;
    pc_f_i            = pc;
    expect_out(nm, e_npc, e_tk, e_hit, e_hent, e_alloc);
  endtask

  initial begin
    // Reset held low.
    #2;
    expect_out("reset_hold", 32'h104, 0, 0, 5'd0, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    expect_out("reset_release", 32'h104, 0, 0, 5'd0, 0);

    // Allocate 0x200 -> 0x400 into entry 7.
    cyc("alloc_req", 1, 1, 32'h200, 32'h400, 0, 5'd7, 32'h300, 32'h304, 0, 0, 5'd0, 1);
    cyc("alloc_lookup", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h200, 32'h400, 1, 0, 5'd0, 0);

    // Not-taken training; same-cycle lookup sees the old prediction.
    cyc("nt1_same_cycle", 1, 0, 32'h200, 32'h0, 0, 5'd0, 32'h200, 32'h400, 1, 1, 5'd7, 0);
    cyc("nt2_cnt1", 1, 0, 32'h200, 32'h0, 0, 5'd0, 32'h200, 32'h204, 0, 1, 5'd7, 0);
    // cnt now 0; four taken updates must saturate at 3.
    cyc("t1_cnt0", 1, 1, 32'h200, 32'h400, 0, 5'd0, 32'h200, 32'h204, 0, 1, 5'd7, 0);
    cyc("t2_cnt1", 1, 1, 32'h200, 32'h400, 0, 5'd0, 32'h200, 32'h204, 0, 1, 5'd7, 0);
    cyc("t3_cnt2", 1, 1, 32'h200, 32'h400, 0, 5'd0, 32'h200, 32'h400, 1, 1, 5'd7, 0);
    cyc("t4_cnt3", 1, 1, 32'h200, 32'h400, 0, 5'd0, 32'h200, 32'h400, 1, 1, 5'd7, 0);
    cyc("nt_from_sat", 1, 0, 32'h200, 32'h0, 0, 5'd0, 32'h200, 32'h400, 1, 1, 5'd7, 0);
    cyc("sat_check", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h200, 32'h400, 1, 0, 5'd0, 0);

    // Retarget to 0x800 (cnt 2 -> 3).
    cyc("retarget_req", 1, 1, 32'h200, 32'h800, 0, 5'd3, 32'h200, 32'h400, 1, 1, 5'd7, 0);
    cyc("retarget_lookup", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h202, 32'h800, 1, 0, 5'd0, 0);

    // Highest entry index.
    cyc("alloc31_req", 1, 1, 32'h1000, 32'h2000, 0, 5'd31, 32'h1000, 32'h1004, 0, 0, 5'd0, 1);
    cyc("alloc31_hit", 1, 0, 32'h1000, 32'h0, 0, 5'd0, 32'h1000, 32'h2000, 1, 1, 5'd31, 0);

    // Not-taken miss: nothing allocated.
    cyc("nt_miss_req", 1, 0, 32'h3000, 32'h3100, 0, 5'd3, 32'h3000, 32'h3004, 0, 0, 5'd0, 0);
    cyc("nt_miss_lookup", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h3000, 32'h3004, 0, 0, 5'd0, 0);

    // Fetch PC wrap.
    cyc("pc_wrap", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'hFFFF_FFFC, 32'h0, 0, 0, 5'd0, 0);

    // Invalidate with a taken miss: no allocation, then everything misses.
    cyc("inv_req", 1, 1, 32'h7000, 32'h7100, 1, 5'd4, 32'h200, 32'h800, 1, 0, 5'd0, 0);
    cyc("inv_lookup_200", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h200, 32'h204, 0, 0, 5'd0, 0);
    cyc("inv_lookup_1000", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h1000, 32'h1004, 0, 0, 5'd0, 0);
    cyc("inv_lookup_7000", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h7000, 32'h7004, 0, 0, 5'd0, 0);
    cyc("post_inv_realloc", 1, 1, 32'h200, 32'h400, 0, 5'd2, 32'h204, 32'h208, 0, 0, 5'd0, 1);
    cyc("post_inv_lookup", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h200, 32'h400, 1, 0, 5'd0, 0);

    // Reset asserted mid-request: request not written, table cleared.
    cyc("rst_mid_req", 1, 1, 32'h5000, 32'h6000, 0, 5'd9, 32'h5000, 32'h5004, 0, 0, 5'd0, 1);
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    cyc("rst_mid_hold", 1, 1, 32'h5000, 32'h6000, 0, 5'd9, 32'h200, 32'h204, 0, 0, 5'd0, 0);
    @(negedge clk);
    #1;
    branch_request_i = 1'b0;
    rst_ni = 1'b1;
    cyc("rst_mid_lookup", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h5000, 32'h5004, 0, 0, 5'd0, 0);
    cyc("rst_mid_cleared", 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h200, 32'h204, 0, 0, 5'd0, 0);

    // Let the monitor drain; anything left over is a missed comparison.
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_pc_btb.md
# next_pc_btb

Fully-associative branch target buffer for the fetch stage of the RV32IM core. It predicts the next fetch PC from the current fetch PC and trains on branch outcomes resolved in execute. It is the consumer of the pseudo-random replacement allocator. It reports update-side hits and allocations to the allocator and writes new entries at the allocator's chosen slot.

## Interface
Parameters:
- DEPTH, 32, number of entries; must equal 2**ADDR_W
- ADDR_W, 5, entry index width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- pc_f_i  in  32  current fetch PC
- next_pc_f_o  out  32  predicted next fetch PC
- next_taken_f_o  out  1  prediction is a taken BTB hit
- branch_request_i  in  1  resolved control-flow instruction valid this cycle
- branch_is_taken_i  in  1  resolved outcome taken
- branch_source_i  in  32  PC of the resolved instruction
- branch_pc_i  in  32  resolved target PC
- invalidate_i  in  1  flush all entries (fence.i)
- hit_o  out  1  update-side hit, to allocator hit_i
- hit_entry_o  out  ADDR_W  index of update-side hit, to allocator hit_entry_i
- alloc_o  out  1  allocation this cycle, to allocator alloc_i
- alloc_entry_i  in  ADDR_W  slot chosen by the allocator

## Operation
- Each entry holds:
  - valid
  - source[31:2]
  - target[31:2]
  - cnt[1:0], a saturating counter
- PC bits [1:0] are ignored everywhere. Targets and predictions are word aligned, and bits [1:0] of next_pc_f_o are 0.
- Lookup (combinational on registered table):
  - match = valid && source == pc_f_i[31:2]. If several entries match, the lowest index wins.
  - On a hit with cnt[1]=1: next_pc_f_o = {target, 2'b00} and next_taken_f_o = 1.
  - Otherwise: next_pc_f_o = {pc_f_i[31:2] + 1, 2'b00} (wraps 0xFFFFFFFC to 0x00000000) and next_taken_f_o = 0.
- Update match (combinational): umatch = valid && source == branch_source_i[31:2], lowest index.
  - hit_o = branch_request_i && umatch && !invalidate_i
  - hit_entry_o = matched index, 0 when no match
- Update on the clock edge when branch_request_i=1 and invalidate_i=0:
  - Hit, taken: cnt = min(cnt+1, 3) and target = branch_pc_i[31:2].
  - Hit, not taken: cnt = max(cnt-1, 0). Target is unchanged. The entry stays valid at cnt=0.
  - Miss, taken: alloc_o=1 (combinational, same cycle). Entry alloc_entry_i is written with valid=1, source, target, cnt=2'b10, overwriting any prior contents.
  - Miss, not taken: no state change and alloc_o=0.
- Invalidate:
  - Clears all valid bits next edge; other fields are don't-care.
  - It takes priority over a same-cycle update: no update, and hit_o=0, alloc_o=0.
- alloc_o is never asserted on a hit. Duplicate sources are therefore not created by the update path.

## Timing
- Prediction is zero latency: next_pc_f_o and next_taken_f_o are a combinational function of pc_f_i and the table state.
- An update at edge N is visible to lookup from cycle N+1. A same-cycle lookup of the entry being updated sees the pre-update contents.
- alloc_o, hit_o and hit_entry_o are combinational and valid only in the branch_request_i cycle. The allocator samples alloc_o on the same edge the entry is written. alloc_entry_i must be stable during the request cycle.
- Reset while rst_ni=0, asynchronously:
  - All valid bits and cnt are 0.
  - Outputs then give next_pc_f_o = pc_f_i + 4 (aligned), next_taken_f_o=0, hit_o=0, hit_entry_o=0, alloc_o=0.
  - Reset mid-update discards the update.
- No handshake or stall: every request is consumed in one cycle.

## Test plan
- Reset: pc_f_i=0x100 with rst_ni low, then released → next_pc_f_o=0x104, next_taken_f_o=0, alloc_o=0.
- Allocate:
  - Stimulus: request with source 0x200, taken, target 0x400, alloc_entry_i=7.
  - Same cycle: alloc_o=1 and hit_o=0.
  - Next cycle, pc_f_i=0x200: next_pc_f_o=0x400 and next_taken_f_o=1.
- Counter training: on entry 7, apply two not-taken updates.
  - After the first: cnt=1 and the prediction for 0x200 is 0x204. hit_o=1 and hit_entry_o=7 each cycle.
  - After three taken updates: cnt saturates at 3 and the prediction is 0x400 again.
- Retarget: apply a taken update for 0x200 with target 0x800 → next cycle predicts 0x800 and alloc_o stays 0.
- Simultaneous events:
  - Invalidate plus a taken miss request in the same cycle → alloc_o=0, then all lookups miss.
  - A lookup of 0x200 in the same cycle as its not-taken update returns the old prediction.
- Boundary:
  - pc_f_i=0xFFFFFFFC with no hit → next_pc_f_o=0x00000000.
  - Allocating entry 31 (ADDR_W=5) then looking it up → hit.
  - Asserting rst_ni low mid-request → no entry written.
